// File: rtl/signext_arbiter.sv
// signext_arbiter: round-robin share of one pipelined sign extender
// between the decode immediate path (0) and the mem load path (1).
module signext_arbiter #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [IN_WIDTH-1:0]  req0_data,
  input  logic                 req0_signed,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [IN_WIDTH-1:0]  req1_data,
  input  logic                 req1_signed,
  output logic                 req1_ready,
  input  logic                 flush0,
  output logic [IN_WIDTH-1:0]  ext_dataIn,
  output logic                 ext_isSigned,
  output logic                 ext_en_n,
  input  logic [OUT_WIDTH-1:0] ext_dataOut,
  output logic                 rsp0_valid,
  output logic [OUT_WIDTH-1:0] rsp0_data,
  output logic                 rsp1_valid,
  output logic [OUT_WIDTH-1:0] rsp1_data
);

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

  logic en_q;
  logic last_grant;
  logic gnt_any;
  logic gnt_own;
  tag_t tags_q [DEPTH];

  // Round-robin pick; nothing is granted until the extender is enabled
  always_comb begin
    gnt_any = 1'b0;
    gnt_own = 1'b0;
    if (en_q) begin
      unique case (1'b1)
        (req0_valid & req1_valid): begin
          gnt_any = 1'b1;
          gnt_own = ~last_grant;
        end
        (req0_valid & ~req1_valid): begin
          gnt_any = 1'b1;
          gnt_own = 1'b0;
        end
        (~req0_valid & req1_valid): begin
          gnt_any = 1'b1;
          gnt_own = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt_any & ~gnt_own;
  assign req1_ready = gnt_any & gnt_own;
  assign ext_en_n   = ~en_q;

  // Steer the granted operand to the extender, zeros when idle
  always_comb begin
    ext_dataIn   = '0;
    ext_isSigned = 1'b0;
    if (gnt_any) begin
      ext_dataIn   = gnt_own ? req1_data : req0_data;
      ext_isSigned = gnt_own ? req1_signed : req0_signed;
    end
  end

  // Enable comes up one edge after reset; remember who won last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      en_q <= 1'b1;
      if (gnt_any) last_grant <= gnt_own;
    end
  end

  // Tag pipe tracks owners in step with the extender; flush kills owner 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
    end else if (en_q) begin
      tags_q[0].vld <= gnt_any & ~(flush0 & ~gnt_own);
      tags_q[0].own <= gnt_own;
      for (int i = 1; i < DEPTH; i++) begin
        tags_q[i].vld <= tags_q[i-1].vld &
                         ~(flush0 & ~tags_q[i-1].own);
        tags_q[i].own <= tags_q[i-1].own;
      end
    end
  end

  assign rsp0_valid = tags_q[DEPTH-1].vld & ~tags_q[DEPTH-1].own;
  assign rsp1_valid = tags_q[DEPTH-1].vld & tags_q[DEPTH-1].own;
  assign rsp0_data  = ext_dataOut;
  assign rsp1_data  = ext_dataOut;

endmodule

// File: tb/tb_signext_arbiter.sv
// tb_signext_arbiter: three DUTs (DEPTH 1,2,3) on shared stimulus,
// checked against a time-slot schedule model of expected responses.
module tb_signext_arbiter;

  logic clk;
  logic rst;
  logic v0, s0, v1, s1, flush0;
  logic [15:0] d0, d1;

  logic [2:0] rdy0, rdy1, en_n, sg, r0v, r1v;
  logic [2:0][15:0] din;
  logic [2:0][31:0] dout, r0d, r1d;

  int nvec;
  int nerr;
  int cyc;

  bit en_m;
  bit lg_m;
  bit mg_any;
  bit mg_own;
  bit ev [3][8];
  bit eo [3][8];
  logic [31:0] evl [3][8];

  function automatic logic [31:0] ext32(input logic [15:0] d,
                                        input logic s);
    return s ? {{16{d[15]}}, d} : {16'h0, d};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = g + 1;
    logic [31:0] pipe [D];

    signext_arbiter #(.IN_WIDTH(16), .OUT_WIDTH(32), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_data(d0), .req0_signed(s0),
      .req0_ready(rdy0[g]),
      .req1_valid(v1), .req1_data(d1), .req1_signed(s1),
      .req1_ready(rdy1[g]),
      .flush0(flush0),
      .ext_dataIn(din[g]), .ext_isSigned(sg[g]), .ext_en_n(en_n[g]),
      .ext_dataOut(dout[g]),
      .rsp0_valid(r0v[g]), .rsp0_data(r0d[g]),
      .rsp1_valid(r1v[g]), .rsp1_data(r1d[g])
    );

    // behavioural pipelined extender
    always @(posedge clk) begin
      if (!en_n[g]) begin
        for (int k = D - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= ext32(din[g], sg[g]);
      end
    end
    assign dout[g] = pipe[D-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) ev[i][k] = 1'b0;
  endtask

  // check every output of every instance against the model
  task automatic settle();
    int s;
    #1;
    if (rst) begin
      en_m = 1'b0;
      lg_m = 1'b1;
      clear_model();
    end
    mg_any = 1'b0;
    mg_own = 1'b0;
    if (en_m && (v0 || v1)) begin
      mg_any = 1'b1;
      mg_own = (v0 && v1) ? !lg_m : v1;
    end
    s = cyc % 8;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d ready0", i + 1), rdy0[i], mg_any && !mg_own);
      chk($sformatf("d%0d ready1", i + 1), rdy1[i], mg_any && mg_own);
      chk($sformatf("d%0d en_n", i + 1), en_n[i], !en_m);
      chk($sformatf("d%0d dataIn", i + 1), din[i],
          mg_any ? (mg_own ? d1 : d0) : 16'h0);
      chk($sformatf("d%0d isSigned", i + 1), sg[i],
          mg_any ? (mg_own ? s1 : s0) : 1'b0);
      chk($sformatf("d%0d rsp0_valid", i + 1), r0v[i],
          ev[i][s] && !eo[i][s]);
      chk($sformatf("d%0d rsp1_valid", i + 1), r1v[i],
          ev[i][s] && eo[i][s]);
      if (ev[i][s])
        chk($sformatf("d%0d rsp_data", i + 1),
            eo[i][s] ? r1d[i] : r0d[i], evl[i][s]);
    end
  endtask

  // apply the coming clock edge to the model, then move to next cycle
  task automatic adv();
    int sl;
    if (!rst) begin
      if (flush0)
        for (int i = 0; i < 3; i++)
          for (int k = 1; k <= i + 1; k++) begin
            sl = (cyc + k) % 8;
            if (!eo[i][sl]) ev[i][sl] = 1'b0;
          end
      if (mg_any) begin
        for (int i = 0; i < 3; i++) begin
          sl = (cyc + i + 1) % 8;
          ev[i][sl]  = !(flush0 && !mg_own);
          eo[i][sl]  = mg_own;
          evl[i][sl] = ext32(mg_own ? d1 : d0, mg_own ? s1 : s0);
        end
        lg_m = mg_own;
      end
    end
    for (int i = 0; i < 3; i++) ev[i][cyc % 8] = 1'b0;
    en_m = !rst;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    v0 = 1'b0;
    v1 = 1'b0;
    flush0 = 1'b0;
    repeat (n) begin
      settle();
      adv();
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc = 0;
    en_m = 1'b0;
    lg_m = 1'b1;
    clear_model();
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; s0 = 1'b0; s1 = 1'b0;
    d0 = 16'h0; d1 = 16'h0; flush0 = 1'b0;
    @(negedge clk);

    // reset state
    settle();
    chk("rst en_n", en_n[0], 1'b1);
    chk("rst ready0", rdy0[0], 1'b0);
    adv();

    // startup: not ready until enable rises
    rst = 1'b0;
    v0 = 1'b1; d0 = 16'h8001; s0 = 1'b1;
    settle();
    chk("startup ready0", rdy0[0], 1'b0);
    chk("startup en_n", en_n[0], 1'b1);
    adv();
    settle();
    chk("enabled en_n", en_n[0], 1'b0);
    chk("enabled ready0", rdy0[0], 1'b1);
    adv();
    v0 = 1'b0;
    settle();
    chk("sext rsp0_valid", r0v[0], 1'b1);
    chk("sext rsp0_data", r0d[0], 32'hFFFF8001);
    adv();
    v0 = 1'b1; s0 = 1'b0;
    settle();
    adv();
    v0 = 1'b0;
    settle();
    chk("zext rsp0_data", r0d[0], 32'h00008001);
    adv();
    idle(4);

    // make requester 1 the last winner, then contend
    v1 = 1'b1; d1 = 16'h1234; s1 = 1'b0;
    settle();
    adv();
    idle(4);
    d0 = 16'h00FF; s0 = 1'b0;
    d1 = 16'hFF80; s1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v0 = (i < 4);
      v1 = (i < 4);
      settle();
      if (i < 4) chk("rr ready0", rdy0[0], (i % 2) == 0);
      if (i > 0) begin
        chk("rr rsp0_valid", r0v[0], ((i - 1) % 2) == 0);
        chk("rr rsp1_valid", r1v[0], ((i - 1) % 2) == 1);
        if ((i - 1) % 2 == 0) chk("rr rsp0_data", r0d[0], 32'h000000FF);
        else chk("rr rsp1_data", r1d[0], 32'hFFFFFF80);
      end
      adv();
    end
    idle(4);

    // flush kills in-flight req0, not req1
    v0 = 1'b1; d0 = 16'h0001; s0 = 1'b0;
    settle();
    adv();
    v0 = 1'b0; flush0 = 1'b1;
    v1 = 1'b1; d1 = 16'h8000; s1 = 1'b1;
    settle();
    chk("flush same-cycle rsp0", r0v[0], 1'b1);
    adv();
    flush0 = 1'b0; v1 = 1'b0;
    settle();
    chk("flush d2 rsp0", r0v[1], 1'b0);
    adv();
    settle();
    chk("flush d3 rsp0", r0v[2], 1'b0);
    adv();
    settle();
    chk("flush d3 rsp1_valid", r1v[2], 1'b1);
    chk("flush d3 rsp1_data", r1d[2], 32'hFFFF8000);
    adv();
    idle(4);

    // reset with two operations in flight
    v0 = 1'b1; d0 = 16'h00AA; s0 = 1'b0;
    settle();
    adv();
    v0 = 1'b0; v1 = 1'b1; d1 = 16'h0055; s1 = 1'b0;
    settle();
    adv();
    v1 = 1'b0; rst = 1'b1;
    settle();
    chk("rst kill d1 rsp1", r1v[0], 1'b0);
    adv();
    settle();
    chk("rst kill d3 rsp0", r0v[2], 1'b0);
    adv();
    rst = 1'b0;
    settle();
    chk("rst kill d3 rsp1", r1v[2], 1'b0);
    adv();
    v1 = 1'b1;
    settle();
    adv();
    v1 = 1'b0;
    settle();
    chk("resume rsp1_valid", r1v[0], 1'b1);
    chk("resume rsp1_data", r1d[0], 32'h00000055);
    adv();
    idle(4);

    // back-to-back req1 on DEPTH 2
    s1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v1 = (i < 8);
      d1 = 16'h8000 + 16'(i);
      settle();
      if (i >= 2) begin
        chk("b2b rsp1_valid", r1v[1], 1'b1);
        chk("b2b rsp1_data", r1d[1], 32'hFFFF8000 + 32'(i - 2));
      end
      adv();
    end
    idle(4);

    // random traffic with flushes and occasional resets
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      s0 = $urandom_range(0, 1);
      s1 = $urandom_range(0, 1);
      flush0 = ($urandom_range(0, 6) == 0);
      settle();
      adv();
    end
    rst = 1'b0;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/signext_arbiter.md
# signext_arbiter

Arbitrates one shared, pipelined sign extender between two requesters in the pipelined MIPS core. Requester 0 is the decode-stage immediate path and requester 1 is the memory-stage load-byte/halfword path. Each cycle the block grants at most one request using round-robin priority and drives the extender's data, mode and enable inputs. It tracks every in-flight operation through a DEPTH-stage tag pipeline and returns each result to its owner, discarding requester-0 results that were killed by a pipeline flush.

## Interface
Parameters:
- IN_WIDTH, 16, request data width
- OUT_WIDTH, 32, extended result width
- DEPTH, 1, extender latency in cycles (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_data  input  IN_WIDTH  value to extend
- req0_signed  input  1  1 = sign-extend, 0 = zero-extend
- req0_ready  output  1  request 0 accepted this cycle when valid
- req1_valid / req1_data / req1_signed / req1_ready  same as requester 0
- flush0  input  1  kill all in-flight requester-0 operations
- ext_dataIn  output  IN_WIDTH  to extender dataIn
- ext_isSigned  output  1  to extender isSigned
- ext_en_n  output  1  to extender en_n, active-low enable
- ext_dataOut  input  OUT_WIDTH  from extender dataOut
- rsp0_valid  output  1  result for requester 0 valid
- rsp0_data  output  OUT_WIDTH  result for requester 0
- rsp1_valid / rsp1_data  same for requester 1

## Operation
- State:
  - en_q: registered, reset 0.
  - ext_en_n = ~en_q.
  - last_grant: reset 1.
  - Tag pipe of DEPTH stages, each holding {valid, owner}, reset all 0.
- Startup: en_q goes to 1 on the first clock edge after rst deasserts. Both ready outputs are 0 while en_q = 0.
- Arbitration (combinational, only when en_q = 1):
  - One valid requester: grant it.
  - Both valid: grant ~last_grant.
  - Neither valid: no grant.
- req*_ready equals the grant. The ready signal does not depend on its own requester's valid beyond the arbitration rule, so there is no combinational loop.
- Acceptance:
  - Drive ext_dataIn and ext_isSigned from the granted requester in the same cycle.
  - With no grant, drive 0 and 0.
  - Stage 0 of the tag pipe loads {1, owner}.
  - last_grant updates only when a grant occurs.
- Tag pipe: shifts every cycle while en_q = 1.
- Result output:
  - rsp*_data = ext_dataOut every cycle.
  - rsp*_valid = last-stage valid AND owner matches.
  - At most one rsp*_valid is high in any cycle.
- Flush:
  - flush0 = 1 clears the valid bit of every stage whose owner is 0, including a stage-0 load occurring in the same cycle.
  - Requester-1 entries are unaffected.
  - req0_ready is still reported during a flush.
- Responses have no back-pressure. Owners must sink the result in the cycle it is presented.

## Timing
- Reset values:
  - req*_ready 0
  - rsp*_valid 0
  - ext_en_n 1
  - ext_dataIn 0
  - ext_isSigned 0
- Latency: a request accepted at cycle N produces rsp_valid in cycle N+DEPTH.
- Throughput: one accept per cycle sustained. Under continuous contention, grants alternate 0,1,0,1.
- Reset asserted mid-operation: all tags clear immediately and asynchronously, and no stale response is ever issued.
- Flush in the same cycle as a requester-0 result (last stage, owner 0): rsp0_valid is still 1 that cycle. Flush affects only the registered next state.

## Test plan
- Reset, then idle: ext_en_n goes 1→0 one cycle after rst falls; ready signals are 0 before that; no rsp_valid occurs.
- req0 only, data 0x8001, signed=1, DEPTH=1: accepted at N, rsp0_valid at N+1 with 0xFFFF8001. Repeat with signed=0 → 0x00008001.
- Both requesters valid for 4 cycles, req0 0x00FF unsigned and req1 0xFF80 signed: grants go 0,1,0,1; responses alternate 0x000000FF and 0xFFFFFF80 to the correct owner.
- req0 accepted at N with DEPTH=3, flush0 at N+1: no rsp0_valid at N+3. A req1 accepted at N+1 still yields rsp1_valid at N+4.
- rst asserted at N+1 with two operations in flight: all rsp_valid stay 0 afterwards, and operation resumes cleanly after startup.
- Back-to-back req1 only, 8 cycles with DEPTH=2: 8 consecutive rsp1_valid pulses in request order, no gaps.
